// File: rtl/keysearch_scheduler.sv
// Hands out fixed-size key chunks to a pool of RC4 cores and collects the first hit.
// Optional macro KEYSEARCH_PERF_EN adds saturating busy-cycle and grant counters.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_IDLE       | waiting for start
// S_DISPATCH   | granting chunks round-robin until the keyspace is exhausted
// S_DRAIN      | keyspace handed out, waiting for outstanding cores to finish
// S_DONE       | search over; succeeded tells whether a key was found
module keysearch_scheduler #(
   parameter int                   NUM_CORES = 4,
   parameter int                   KEY_WIDTH = 24,
   parameter int                   CHUNK_LOG = 10,
   parameter logic [KEY_WIDTH-1:0] KEY_LOWER = '0,
   parameter logic [KEY_WIDTH-1:0] KEY_UPPER = {KEY_WIDTH{1'b1}}
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [NUM_CORES-1:0]           core_req,
   input  logic [NUM_CORES-1:0]           core_found,
   input  logic [NUM_CORES*KEY_WIDTH-1:0] core_found_key,
   output logic [NUM_CORES-1:0]           core_grant,
   output logic [KEY_WIDTH-1:0]           core_base,
   output logic [KEY_WIDTH-1:0]           core_limit,
   output logic                           core_abort,
   output logic                           busy,
   output logic                           succeeded,
   output logic                           terminated,
   output logic [KEY_WIDTH-1:0]           found_key,
   output logic [31:0]                    perf_cycles,
   output logic [15:0]                    perf_chunks
);

   localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam logic [KEY_WIDTH:0] CHUNK_SIZE = {{KEY_WIDTH{1'b0}}, 1'b1} << CHUNK_LOG;
   localparam logic [KEY_WIDTH:0] LOWER_EXT  = {1'b0, KEY_LOWER};
   localparam logic [KEY_WIDTH:0] UPPER_EXT  = {1'b0, KEY_UPPER};

   typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_DONE} state_t;

   state_t                 state_q, state_nxt;
   logic [KEY_WIDTH:0]     next_base;
   logic [KEY_WIDTH:0]     base_plus;
   logic [KEY_WIDTH-1:0]   chunk_limit;
   logic [KEY_WIDTH-1:0]   found_sel;
   logic [NUM_CORES-1:0]   outstanding;
   logic [NUM_CORES-1:0]   eligible;
   logic [NUM_CORES-1:0]   grant_onehot;
   logic [PTR_W-1:0]       rr_ptr;
   logic [PTR_W-1:0]       grant_idx;
   logic                   grant_vld;
   logic                   exhausted;
   logic                   any_found;
   logic                   start_fire;
   logic                   grant_fire;
   logic                   found_fire;

   assign eligible    = core_req & ~outstanding;
   // next_base carries one extra bit so the last chunk cannot wrap to key 0
   assign exhausted   = next_base > UPPER_EXT;
   assign base_plus   = next_base + (CHUNK_SIZE - 1'b1);
   assign chunk_limit = (base_plus > UPPER_EXT) ? KEY_UPPER : base_plus[KEY_WIDTH-1:0];
   assign any_found   = |core_found;

   assign busy       = (state_q == S_DISPATCH) || (state_q == S_DRAIN);
   assign terminated = (state_q == S_DONE);
   assign core_abort = (state_q == S_DONE) && succeeded;

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
         int cand;
         cand = int'(rr_ptr) + k;
         if (cand >= NUM_CORES) cand = cand - NUM_CORES;
         if (!grant_vld && eligible[PTR_W'(cand)]) begin
            grant_vld = 1'b1;
            grant_idx = PTR_W'(cand);
         end
      end
   end

   // lowest index wins on simultaneous hits
   always_comb begin
      found_sel = '0;
      for (int k = NUM_CORES - 1; k >= 0; k--) begin
         if (core_found[k]) found_sel = core_found_key[k*KEY_WIDTH +: KEY_WIDTH];
      end
   end

   always_comb begin
      state_nxt  = state_q;
      start_fire = 1'b0;
      grant_fire = 1'b0;
      found_fire = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               start_fire = 1'b1;
               state_nxt  = S_DISPATCH;
            end
         end
         S_DISPATCH: begin
            if (any_found) begin
               found_fire = 1'b1;
               state_nxt  = S_DONE;
            end else if (exhausted) begin
               state_nxt  = S_DRAIN;
            end else begin
               grant_fire = grant_vld;
            end
         end
         S_DRAIN: begin
            if (any_found) begin
               found_fire = 1'b1;
               state_nxt  = S_DONE;
            end else if (outstanding == '0) begin
               state_nxt  = S_DONE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign grant_onehot = grant_fire ? (NUM_CORES'(1) << grant_idx) : '0;

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         next_base   <= '0;
         outstanding <= '0;
         rr_ptr      <= '0;
         core_grant  <= '0;
         core_base   <= '0;
         core_limit  <= '0;
         succeeded   <= 1'b0;
         found_key   <= '0;
      end else begin
         core_grant <= '0;
         if (start_fire) begin
            next_base   <= LOWER_EXT;
            outstanding <= '0;
            succeeded   <= 1'b0;
            found_key   <= '0;
         end else begin
            // a request seen while the grant pulse is still up is the stale one
            outstanding <= (outstanding & ~(core_req & ~core_grant)) | grant_onehot;
            if (grant_fire) begin
               core_grant <= grant_onehot;
               core_base  <= next_base[KEY_WIDTH-1:0];
               core_limit <= chunk_limit;
               next_base  <= next_base + CHUNK_SIZE;
               rr_ptr     <= (grant_idx == PTR_W'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (found_fire) begin
               succeeded <= 1'b1;
               found_key <= found_sel;
            end
         end
      end
   end

`ifdef KEYSEARCH_PERF_EN
   logic [31:0] perf_cycles_q;
   logic [15:0] perf_chunks_q;

   always_ff @(posedge clk) begin
      if (reset || start_fire) begin
         perf_cycles_q <= '0;
         perf_chunks_q <= '0;
      end else begin
         if (busy && (perf_cycles_q != '1))       perf_cycles_q <= perf_cycles_q + 1'b1;
         if (grant_fire && (perf_chunks_q != '1)) perf_chunks_q <= perf_chunks_q + 1'b1;
      end
   end

   assign perf_cycles = perf_cycles_q;
   assign perf_chunks = perf_chunks_q;
`else
   assign perf_cycles = '0;
   assign perf_chunks = '0;
`endif

endmodule

// File: tb/tb_keysearch_scheduler.sv
// Scoreboard bench: two schedulers, one with a clamped last chunk (upper=13)
// and one at the top of the keyspace to catch wrap-around.
module tb_keysearch_scheduler;

   localparam int NC = 4;
   localparam int KW = 24;

   typedef struct packed {
      logic [NC-1:0] grant;
      logic [KW-1:0] base;
      logic [KW-1:0] limit;
   } exp_t;

   logic           clk = 1'b0;
   logic           reset, start;
   logic [NC-1:0]  req_a, req_b, found_a;
   logic [NC*KW-1:0] fkey_a;
   logic [NC-1:0]  core_grant_a, core_grant_b;
   logic [KW-1:0]  core_base_a, core_limit_a, core_base_b, core_limit_b;
   logic [KW-1:0]  found_key_a, found_key_b;
   logic           core_abort_a, busy_a, succeeded_a, terminated_a;
   logic           core_abort_b, busy_b, succeeded_b, terminated_b;
   logic [31:0]    perf_cycles_a, perf_cycles_b;
   logic [15:0]    perf_chunks_a, perf_chunks_b;

   exp_t exp_q_a[$];
   exp_t exp_q_b[$];
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   keysearch_scheduler #(.NUM_CORES(NC), .KEY_WIDTH(KW), .CHUNK_LOG(2),
                         .KEY_LOWER(24'h0), .KEY_UPPER(24'd13)) dut_a (
      .clk(clk), .reset(reset), .start(start), .core_req(req_a),
      .core_found(found_a), .core_found_key(fkey_a),
      .core_grant(core_grant_a), .core_base(core_base_a), .core_limit(core_limit_a),
      .core_abort(core_abort_a), .busy(busy_a), .succeeded(succeeded_a),
      .terminated(terminated_a), .found_key(found_key_a),
      .perf_cycles(perf_cycles_a), .perf_chunks(perf_chunks_a)
   );

   keysearch_scheduler #(.NUM_CORES(NC), .KEY_WIDTH(KW), .CHUNK_LOG(2),
                         .KEY_LOWER(24'hFFFFF8), .KEY_UPPER(24'hFFFFFF)) dut_b (
      .clk(clk), .reset(reset), .start(start), .core_req(req_b),
      .core_found('0), .core_found_key('0),
      .core_grant(core_grant_b), .core_base(core_base_b), .core_limit(core_limit_b),
      .core_abort(core_abort_b), .busy(busy_b), .succeeded(succeeded_b),
      .terminated(terminated_b), .found_key(found_key_b),
      .perf_cycles(perf_cycles_b), .perf_chunks(perf_chunks_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic push_a(input int idx, input logic [KW-1:0] b, input logic [KW-1:0] l);
      exp_q_a.push_back('{grant: NC'(1) << idx, base: b, limit: l});
   endtask

   task automatic push_b(input int idx, input logic [KW-1:0] b, input logic [KW-1:0] l);
      exp_q_b.push_back('{grant: NC'(1) << idx, base: b, limit: l});
   endtask

   // grant monitors
   always @(negedge clk) begin
      if (core_grant_a != '0) begin
         if (exp_q_a.size() == 0) begin
            check("grant_a_unexpected", {28'd0, core_grant_a}, 32'd0);
         end else begin
            exp_t e;
            e = exp_q_a.pop_front();
            check("grant_a_core",  {28'd0, core_grant_a}, {28'd0, e.grant});
            check("grant_a_base",  {8'd0, core_base_a},   {8'd0, e.base});
            check("grant_a_limit", {8'd0, core_limit_a},  {8'd0, e.limit});
         end
      end
      if (core_grant_b != '0) begin
         if (exp_q_b.size() == 0) begin
            check("grant_b_unexpected", {28'd0, core_grant_b}, 32'd0);
         end else begin
            exp_t e;
            e = exp_q_b.pop_front();
            check("grant_b_core",  {28'd0, core_grant_b}, {28'd0, e.grant});
            check("grant_b_base",  {8'd0, core_base_b},   {8'd0, e.base});
            check("grant_b_limit", {8'd0, core_limit_b},  {8'd0, e.limit});
         end
      end
   end

   task automatic start_pulse();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_term_a(input string tag);
      int n = 0;
      while (!terminated_a && n < 100) begin
         @(negedge clk);
         n++;
      end
      check(tag, {31'd0, terminated_a}, 32'd1);
   endtask

   task automatic wait_term_b(input string tag);
      int n = 0;
      while (!terminated_b && n < 100) begin
         @(negedge clk);
         n++;
      end
      check(tag, {31'd0, terminated_b}, 32'd1);
   endtask

   task automatic wait_grant_a(input int idx, input string tag);
      int n = 0;
      while (!core_grant_a[idx] && n < 100) begin
         @(negedge clk);
         n++;
      end
      check(tag, {31'd0, core_grant_a[idx]}, 32'd1);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_busy"},       {31'd0, busy_a},        32'd0);
      check({tag, "_terminated"}, {31'd0, terminated_a},  32'd0);
      check({tag, "_succeeded"},  {31'd0, succeeded_a},   32'd0);
      check({tag, "_abort"},      {31'd0, core_abort_a},  32'd0);
      check({tag, "_grant"},      {28'd0, core_grant_a},  32'd0);
      check({tag, "_base"},       {8'd0, core_base_a},    32'd0);
      check({tag, "_limit"},      {8'd0, core_limit_a},   32'd0);
      check({tag, "_found_key"},  {8'd0, found_key_a},    32'd0);
      check({tag, "_perf_cyc"},   perf_cycles_a,          32'd0);
      check({tag, "_perf_chk"},   {16'd0, perf_chunks_a}, 32'd0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0;
      req_a = '0; req_b = '0; found_a = '0; fkey_a = '0;
      repeat (3) @(negedge clk);
      check_reset_state("por");
      reset = 1'b0;
      @(negedge clk);

      // full sweep, last chunk clamped; wrap-guard instance in parallel
      push_a(0, 24'd0, 24'd3);  push_a(1, 24'd4, 24'd7);
      push_a(2, 24'd8, 24'd11); push_a(3, 24'd12, 24'd13);
      push_b(0, 24'hFFFFF8, 24'hFFFFFB); push_b(1, 24'hFFFFFC, 24'hFFFFFF);
      req_a = '1; req_b = '1;
      start_pulse();
      check("sweep_busy",        {31'd0, busy_a},       32'd1);
      check("sweep_no_grant_yet",{28'd0, core_grant_a}, 32'd0);
      @(negedge clk);
      check("sweep_first_grant", {28'd0, core_grant_a}, 32'd1);
      wait_term_a("sweep_term_a");
      check("sweep_succeeded",   {31'd0, succeeded_a},  32'd0);
      check("sweep_abort",       {31'd0, core_abort_a}, 32'd0);
      wait_term_b("wrap_term_b");
      check("wrap_succeeded",    {31'd0, succeeded_b},  32'd0);
      req_b = '0;
      repeat (3) @(negedge clk);
      check("wrap_queue_empty",  exp_q_b.size(), 32'd0);

      // hit while draining
      push_a(0, 24'd0, 24'd3);  push_a(1, 24'd4, 24'd7);
      push_a(2, 24'd8, 24'd11); push_a(3, 24'd12, 24'd13);
      start_pulse();
      check("restart_terminated", {31'd0, terminated_a}, 32'd0);
      wait_grant_a(3, "drain_last_grant");
      req_a = '0;
      repeat (3) @(negedge clk);
      check("drain_busy",       {31'd0, busy_a},       32'd1);
      check("drain_terminated", {31'd0, terminated_a}, 32'd0);
      found_a = 4'b0100;
      fkey_a  = {24'd0, 24'h000A49, 24'd0, 24'd0};
      @(negedge clk);
      found_a = '0;
      check("drain_succeeded",  {31'd0, succeeded_a},  32'd1);
      check("drain_found_key",  {8'd0, found_key_a},   32'h000A49);
      check("drain_abort",      {31'd0, core_abort_a}, 32'd1);
      check("drain_busy_off",   {31'd0, busy_a},       32'd0);
      found_a = 4'b0001;
      fkey_a  = {24'd0, 24'd0, 24'd0, 24'h000777};
      @(negedge clk);
      found_a = '0;
      check("done_ignores_found", {8'd0, found_key_a}, 32'h000A49);

      // simultaneous hits in dispatch, no requesting cores
      start_pulse();
      check("restart_clr_succ",  {31'd0, succeeded_a}, 32'd0);
      check("restart_clr_key",   {8'd0, found_key_a},  32'd0);
      check("restart_busy",      {31'd0, busy_a},      32'd1);
      found_a = 4'b1010;
      fkey_a  = {24'd9, 24'd0, 24'd5, 24'd0};
      @(negedge clk);
      found_a = '0;
      check("tie_succeeded",     {31'd0, succeeded_a}, 32'd1);
      check("tie_found_key",     {8'd0, found_key_a},  32'd5);

      // reset in dispatch
      push_a(0, 24'd0, 24'd3);
      req_a = '1;
      start_pulse();
      wait_grant_a(0, "rst_first_grant");
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_reset_state("midrst");

      // found coincident with exhaustion; pointer restarts at core 0
      push_a(0, 24'd0, 24'd3);  push_a(1, 24'd4, 24'd7);
      push_a(2, 24'd8, 24'd11); push_a(3, 24'd12, 24'd13);
      start_pulse();
      wait_grant_a(3, "coin_last_grant");
      found_a = 4'b0010;
      fkey_a  = {24'd0, 24'd0, 24'd3, 24'd0};
      @(negedge clk);
      found_a = '0;
      check("coin_succeeded",    {31'd0, succeeded_a},  32'd1);
      check("coin_found_key",    {8'd0, found_key_a},   32'd3);
      check("coin_terminated",   {31'd0, terminated_a}, 32'd1);
`ifdef KEYSEARCH_PERF_EN
      check("perf_cycles",       perf_cycles_a,          32'd5);
      check("perf_chunks",       {16'd0, perf_chunks_a}, 32'd4);
`else
      check("perf_cycles_tied",  perf_cycles_a,          32'd0);
      check("perf_chunks_tied",  {16'd0, perf_chunks_a}, 32'd0);
`endif
      req_a = '0;
      repeat (3) @(negedge clk);
      check("queue_a_empty", exp_q_a.size(), 32'd0);
      check("queue_b_empty", exp_q_b.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/keysearch_scheduler.md
KEYSEARCH_SCHEDULER -- requirements
Module: keysearch_scheduler

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of RC4 decryption cores served (2..8).
REQ-002 SHALL have parameter KEY_WIDTH, default 24, key bus width.
REQ-003 SHALL have parameter CHUNK_LOG, default 10, chunk size = 2^CHUNK_LOG keys.
REQ-004 SHALL have parameter KEY_LOWER, default 0, first key searched.
REQ-005 SHALL have parameter KEY_UPPER, default 24'hFFFFFF, last key searched (inclusive, >= KEY_LOWER).
REQ-006 clk  input  1  single clock; all logic on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 start  input  1  level/pulse; sampled in IDLE or DONE to begin a search.
REQ-009 core_req  input  NUM_CORES  core i idle and requesting a chunk.
REQ-010 core_found  input  NUM_CORES  one-cycle pulse: core i found a valid key.
REQ-011 core_found_key  input  NUM_CORES*KEY_WIDTH  key from core i, slice i, valid with core_found[i].
REQ-012 core_grant  output  NUM_CORES  one-hot, one-cycle pulse assigning a chunk.
REQ-013 core_base  output  KEY_WIDTH  first key of granted chunk, valid with core_grant.
REQ-014 core_limit  output  KEY_WIDTH  last key (inclusive) of granted chunk, valid with core_grant.
REQ-015 core_abort  output  1  level; all cores stop and return to idle.
REQ-016 busy  output  1  high in DISPATCH and DRAIN.
REQ-017 succeeded  output  1  high in DONE when a key was found.
REQ-018 terminated  output  1  high in DONE.
REQ-019 found_key  output  KEY_WIDTH  latched winning key; valid while succeeded.
REQ-020 perf_cycles  output  32  cycles spent in DISPATCH+DRAIN (see Configuration).
REQ-021 perf_chunks  output  16  chunks granted (see Configuration).

Function
REQ-022 States SHALL be IDLE, DISPATCH, DRAIN, DONE; IDLE->DISPATCH on start, with next_base loaded with KEY_LOWER and outstanding mask cleared.
REQ-023 In DISPATCH, one grant at most per cycle, round-robin among core_req[i] & ~outstanding[i], starting after last granted index.
REQ-024 Grant SHALL drive core_base=next_base, core_limit=min(next_base+2^CHUNK_LOG-1, KEY_UPPER), set outstanding[i], advance next_base by 2^CHUNK_LOG.
REQ-025 Chunk arithmetic SHALL use KEY_WIDTH+1 bits; carry-out or next_base>KEY_UPPER marks keyspace exhausted (no wrap).
REQ-026 outstanding[i] SHALL clear when core_req[i] is sampled high at least one cycle after its grant.
REQ-027 Exhausted in DISPATCH SHALL move to DRAIN; DRAIN->DONE (succeeded=0) when outstanding is all zero.
REQ-028 Any core_found in DISPATCH or DRAIN SHALL latch found_key, go to DONE with succeeded=1; simultaneous hits pick lowest index.
REQ-029 core_found on the same cycle as exhaustion SHALL take priority (succeeded=1).
REQ-030 core_abort SHALL be high in DONE when succeeded=1, low otherwise.
REQ-031 No grant SHALL issue in IDLE, DRAIN or DONE; core_found in IDLE/DONE SHALL be ignored.
REQ-032 start in DONE SHALL restart as from IDLE, clearing succeeded, terminated, found_key next cycle.
REQ-033 Grant latency: core_grant asserted the cycle after core_req is first sampled eligible.

Reset
REQ-034 Reset SHALL force IDLE; core_grant, core_abort, busy, succeeded, terminated =0; found_key, core_base, core_limit =0; outstanding cleared; round-robin pointer =0.
REQ-035 Reset mid-search SHALL take effect next edge, abandoning all chunks without core_abort.

Configuration
REQ-036 Macro KEYSEARCH_PERF_EN defined: perf_cycles counts busy cycles, perf_chunks counts grants, both saturating, cleared on reset and on start.
REQ-037 Macro KEYSEARCH_PERF_EN undefined: perf_cycles and perf_chunks tied to 0, no counter logic.

Verification
REQ-038 NUM_CORES=4, CHUNK_LOG=2, KEY_LOWER=0, KEY_UPPER=15, all core_req high -> grants to cores 0,1,2,3 on consecutive cycles with bases 0,4,8,12, limits 3,7,11,15.
REQ-039 Same, KEY_UPPER=13 -> fourth grant base 12 limit 13; after all cores re-request, terminated=1, succeeded=0.
REQ-040 core_found[2] with key 24'h000A49 during DRAIN -> next cycle succeeded=1, found_key=24'h000A49, core_abort=1.
REQ-041 core_found[1] and [3] same cycle, keys 5 and 9 -> found_key=5.
REQ-042 KEY_UPPER=24'hFFFFFF, KEY_LOWER=24'hFFFFF8, CHUNK_LOG=2 -> two grants (FFFFF8-FFFFFB, FFFFFC-FFFFFF), no wrap to 0.
REQ-043 reset asserted in DISPATCH -> next cycle IDLE, all outputs at reset values; with KEYSEARCH_PERF_EN, perf_chunks=0.
